// File: rtl/ghr_checkpoint_unit.sv
// gshare global-history front end with a checkpoint FIFO for mispredict recovery.
// Define GHR_CKPT_ERR_EN to enable the sticky protocol error flag.
module ghr_checkpoint_unit #(
  parameter int HIST_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic              fetch_is_branch,
  input  logic [31:0]       fetch_pc,
  input  logic              pred_taken,
  input  logic              stall,
  input  logic              branch_resolved,
  input  logic              branch_taken,
  input  logic              mispredict,
  output logic [HIST_W-1:0] index,
  output logic [HIST_W-1:0] ckpt_history,
  output logic [HIST_W-1:0] spec_ghr,
  output logic [HIST_W-1:0] arch_ghr,
  output logic              full,
  output logic              empty,
  output logic              fetch_hold,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [HIST_W-1:0] ckpt_q [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              flush;
  logic              unused_pc;

  assign unused_pc    = ^fetch_pc[31:HIST_W];
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign fetch_hold   = full & fetch_valid & fetch_is_branch;
  assign push         = fetch_valid & fetch_is_branch & ~stall & ~full;
  assign pop          = branch_resolved & ~empty;
  assign flush        = pop & mispredict;
  assign index        = spec_ghr ^ fetch_pc[HIST_W-1:0];
  assign ckpt_history = ckpt_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++)
        ckpt_q[i] <= '0;
    end else begin
      if (pop)
        arch_ghr <= {arch_ghr[HIST_W-2:0], branch_taken};
      // Flush beats any same-cycle push: younger history is wrong-path.
      if (flush) begin
        spec_ghr <= {ckpt_history[HIST_W-2:0], branch_taken};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          ckpt_q[wr_ptr] <= spec_ghr;
          wr_ptr         <= wr_ptr + 1'b1;
          spec_ghr       <= {spec_ghr[HIST_W-2:0], pred_taken};
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef GHR_CKPT_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if ((branch_resolved & empty) |
             (fetch_valid & fetch_is_branch & ~stall & full & ~branch_resolved))
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ghr_checkpoint_unit.sv
// Randomized bench for ghr_checkpoint_unit against a queue-based history model.
module tb_ghr_checkpoint_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_is_branch, pred_taken, stall;
  logic        branch_resolved, branch_taken, mispredict;
  logic [31:0] fetch_pc;
  logic [3:0]  index, ckpt_history, spec_ghr, arch_ghr;
  logic        full, empty, fetch_hold, err;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_spec, m_arch;
  logic       m_err;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  ghr_checkpoint_unit #(.HIST_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_is_branch(fetch_is_branch),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .stall(stall),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .mispredict(mispredict),
    .index(index), .ckpt_history(ckpt_history),
    .spec_ghr(spec_ghr), .arch_ghr(arch_ghr),
    .full(full), .empty(empty), .fetch_hold(fetch_hold), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] shl(input logic [3:0] h, input logic b);
    return (h * 2 + b) % 16;
  endfunction

  task automatic model_reset();
    m_spec = 0;
    m_arch = 0;
    m_err  = 0;
    q.delete();
  endtask

  task automatic compare_all();
    logic [3:0] pc_lo;
    pc_lo = fetch_pc[3:0];
    chk("index", index, m_spec ^ pc_lo);
    chk("full", full, q.size() == 4);
    chk("empty", empty, q.size() == 0);
    chk("fetch_hold", fetch_hold,
        (q.size() == 4) && fetch_valid && fetch_is_branch);
    chk("spec_ghr", spec_ghr, m_spec);
    chk("arch_ghr", arch_ghr, m_arch);
    chk("err", err, m_err);
    if (q.size() > 0) chk("ckpt_history", ckpt_history, q[0]);
  endtask

  task automatic step(input logic fv, input logic fb, input logic [31:0] pc,
                      input logic pt, input logic st, input logic br,
                      input logic bt, input logic mp);
    logic do_push, do_pop;
    logic [3:0] head;
    @(negedge clk);
    fetch_valid = fv; fetch_is_branch = fb; fetch_pc = pc;
    pred_taken = pt; stall = st; branch_resolved = br;
    branch_taken = bt; mispredict = mp;
    #1;
    compare_all();
    do_push = fv && fb && !st && q.size() < 4;
    do_pop  = br && q.size() > 0;
`ifdef GHR_CKPT_ERR_EN
    if ((br && q.size() == 0) || (fv && fb && !st && q.size() == 4 && !br))
      m_err = 1;
`endif
    @(posedge clk);
    if (do_pop) begin
      m_arch = shl(m_arch, bt);
      head = q.pop_front();
      if (mp) begin
        m_spec = shl(head, bt);
        q.delete();
        do_push = 0;
      end
    end
    if (do_push) begin
      q.push_back(m_spec);
      m_spec = shl(m_spec, pt);
    end
    #2;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_valid = 0; fetch_is_branch = 0; fetch_pc = 32'h6;
    pred_taken = 0; stall = 0; branch_resolved = 0;
    branch_taken = 0; mispredict = 0;
    model_reset();
    #12;
    chk("rst_index", index, 4'h6);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_spec", spec_ghr, 4'h0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;

    step(1, 0, 32'h6, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0, 1, 0, 0, 0, 0);
    step(1, 1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0, 1, 0, 0, 0, 0);
    fetch_valid = 0; fetch_pc = 32'hC; #1;
    chk("lit_spec_0101", spec_ghr, 4'b0101);
    chk("lit_index_pcC", index, 4'h9);
    chk("lit_ckpt0", ckpt_history, 4'b0000);
    chk("lit_q_model", {q[0], q[1], q[2]}, 12'h012);

    step(0, 0, 32'hC, 0, 0, 1, 1, 0);
    chk("lit_arch_0001", arch_ghr, 4'b0001);
    chk("lit_ckpt1", ckpt_history, 4'b0001);
    chk("lit_count2", q.size(), 2);
    chk("lit_not_empty", empty, 1'b0);

    step(0, 0, 32'h0, 0, 0, 1, 1, 1);
    chk("lit_spec_0011", spec_ghr, 4'b0011);
    chk("lit_arch_0011", arch_ghr, 4'b0011);
    chk("lit_flush_empty", empty, 1'b1);

    for (int i = 0; i < 4; i++) step(1, 1, 32'h10 + i, i[0], 0, 0, 0, 0);
    chk("lit_full", full, 1'b1);
    step(1, 1, 32'h20, 1, 1, 0, 0, 0);
    chk("lit_hold_full", full, 1'b1);
    step(1, 1, 32'h24, 1, 0, 1, 0, 0);
    chk("lit_resolve_at_full", q.size(), 3);
    step(1, 1, 32'h28, 0, 0, 1, 1, 0);
    chk("lit_push_pop_count", q.size(), 3);

    for (int i = 0; i < 600; i++) begin
      logic br, fb;
      fb = ($urandom_range(0, 99) < 60);
      br = ($urandom_range(0, 99) < 40);
      step($urandom_range(0, 9) < 8, fb, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 9) < 2, br, $urandom_range(0, 1),
           $urandom_range(0, 9) < 2);
      if (i == 300) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_spec", spec_ghr, 4'h0);
        chk("midrst_arch", arch_ghr, 4'h0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_err", err, 1'b0);
        #2 rst = 1'b0;
      end
    end

    model_reset();
    rst = 1'b1; #3; rst = 1'b0;
    step(0, 0, 32'h0, 0, 0, 1, 1, 0);
    idle();
`ifdef GHR_CKPT_ERR_EN
    chk("lit_err_sticky", err, 1'b1);
`else
    chk("lit_err_off", err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
